// File: rtl/seg_digit_driver_pkg.sv
// seg_digit_driver_pkg: anode patterns and hex segment table shared by the digit driver.
package seg_digit_driver_pkg;
  localparam logic [3:0] AN_R    = 4'b1110;
  localparam logic [3:0] AN_RC   = 4'b1101;
  localparam logic [3:0] AN_LC   = 4'b1011;
  localparam logic [3:0] AN_L    = 4'b0111;
  localparam logic [3:0] AN_NONE = 4'b1111;
  localparam logic [6:0] SEG_OFF = 7'h7F;
  // Active-low gfedcba patterns, entry n is hex digit n.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };
endpackage

// File: rtl/seg_digit_driver_hex_to_seg.sv
// hex_to_seg: combinational nibble to active-low seven-segment lookup.
module hex_to_seg
  import seg_digit_driver_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg_n
);
  assign seg_n = HEX_SEG[nib];
endmodule

// File: rtl/seg_digit_driver.sv
// seg_digit_driver: drives shared segment cathodes from scanner anodes with frame-synchronous double-buffered value.
module seg_digit_driver
  import seg_digit_driver_pkg::*;
#(
  parameter int BLINK_DIV_W = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  an_n,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  input  logic        load,
  output logic        ready,
  input  logic        blank_lz,
  input  logic        blink_en,
  input  logic        err_clr,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic        an_err
);
  logic [15:0] active, pending, cur;
  logic [3:0] prev_an, nib;
  logic [BLINK_DIV_W-1:0] cnt;
  logic [1:0] k;
  logic sel, illegal, boundary, blank, off;
  logic [6:0] hex;
  always_comb begin
    sel = an_n inside {AN_R, AN_RC, AN_LC, AN_L};
    illegal = !sel && an_n != AN_NONE;
    k = an_n == AN_RC ? 2'd1 : an_n == AN_LC ? 2'd2 : an_n == AN_L ? 2'd3 : 2'd0;
    boundary = an_n == AN_R && prev_an != AN_R;
    // Forward the committing value so the whole digit0 dwell shows the new frame.
    cur = boundary && !ready ? pending : active;
    nib = cur[{k, 2'b00} +: 4];
    blank = blank_lz && k != 2'd0 && (cur >> {k, 2'b00}) == 16'd0;
    off = !sel || blank || (blink_en && cnt[BLINK_DIV_W-1]);
  end
  hex_to_seg u_hex (.nib(nib), .seg_n(hex));
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active  <= '0;
      pending <= '0;
      ready   <= 1'b1;
      cnt     <= '0;
      prev_an <= AN_NONE;
      an_err  <= 1'b0;
      seg_n   <= SEG_OFF;
      dp_n    <= 1'b1;
    end else begin
      prev_an <= an_n;
      cnt     <= cnt + BLINK_DIV_W'(1);
      seg_n   <= off ? SEG_OFF : hex;
      dp_n    <= off | ~dp[k];
      an_err  <= illegal | (an_err & ~err_clr);
      if (load && ready) begin
        pending <= value;
        ready   <= 1'b0;
      end else if (!ready && boundary) begin
        active <= pending;
        ready  <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_seg_digit_driver.sv
// tb_seg_digit_driver: directed stimulus with a queued scoreboard checked by a negedge monitor.
module tb_seg_digit_driver;
  logic clk = 1'b0, reset = 1'b0;
  logic [3:0] an_n = 4'b1111, dp = 4'b0000;
  logic [15:0] value = 16'h0000;
  logic load = 1'b0, blank_lz = 1'b0, blink_en = 1'b0, err_clr = 1'b0;
  logic ready, dp_n, an_err;
  logic [6:0] seg_n;

  seg_digit_driver #(.BLINK_DIV_W(4)) dut (
    .clk(clk), .reset(reset), .an_n(an_n), .value(value), .dp(dp), .load(load),
    .ready(ready), .blank_lz(blank_lz), .blink_en(blink_en), .err_clr(err_clr),
    .seg_n(seg_n), .dp_n(dp_n), .an_err(an_err)
  );

  always #5 clk = ~clk;

  localparam int K_SEG = 0, K_DP = 1, K_RDY = 2, K_ERR = 3;
  localparam logic [6:0] OFF = 7'h7F;

  typedef struct {
    int due;
    int kind;
    logic [6:0] exp;
    string name;
  } sb_t;

  sb_t q[$];
  int cyc = 0, n_tests = 0, n_fail = 0;
  logic [3:0] bc;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk or negedge reset) bc <= !reset ? 4'd0 : bc + 4'd1;

  sb_t e;
  logic [6:0] act;
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      act = e.kind == K_SEG ? seg_n : e.kind == K_DP ? {6'd0, dp_n} :
            e.kind == K_RDY ? {6'd0, ready} : {6'd0, an_err};
      n_tests++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %b expected %b (cycle %0d)", e.name, act, e.exp, cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_at(input int due, input int kind, input logic [6:0] v, input string name);
    q.push_back('{due, kind, v, name});
  endtask

  task automatic chk(input int kind, input logic [6:0] v, input string name);
    chk_at(cyc + 1, kind, v, name);
  endtask

  task automatic dwell(input logic [3:0] an, input logic [6:0] s, input logic d, input string name);
    for (int i = 0; i < 4; i++) begin
      an_n = an;
      chk(K_SEG, s, {name, "_seg"});
      chk(K_DP, {6'd0, d}, {name, "_dp"});
      tick();
      load = 1'b0;
    end
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk_at(cyc, K_SEG, OFF, {name, "_seg"});
    chk_at(cyc, K_DP, 7'd1, {name, "_dp"});
    chk_at(cyc, K_RDY, 7'd1, {name, "_ready"});
    chk_at(cyc, K_ERR, 7'd0, {name, "_err"});
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic idle_load(input logic [15:0] v, input string name);
    an_n = 4'b1111;
    value = v;
    load = 1'b1;
    chk(K_RDY, 7'd0, name);
    tick();
    load = 1'b0;
  endtask

  initial begin
    do_reset("rst0");
    // Basic load and first commit
    dp = 4'b0100;
    idle_load(16'h1234, "load1234_ack");
    chk(K_RDY, 7'd1, "commit1234_ready");
    dwell(4'b1110, 7'b0011001, 1'b1, "f1_d0");
    dwell(4'b1101, 7'b0110000, 1'b1, "f1_d1");
    dwell(4'b1011, 7'b0100100, 1'b0, "f1_d2");
    dwell(4'b0111, 7'b1111001, 1'b1, "f1_d3");
    // Mid-frame load, then an ignored second load
    dp = 4'b0000;
    dwell(4'b1110, 7'b0011001, 1'b1, "f2_d0");
    dwell(4'b1101, 7'b0110000, 1'b1, "f2_d1");
    value = 16'hABCD;
    load = 1'b1;
    chk(K_RDY, 7'd0, "loadABCD_ack");
    dwell(4'b1011, 7'b0100100, 1'b1, "f2_d2");
    value = 16'hFFFF;
    load = 1'b1;
    chk(K_RDY, 7'd0, "loadFFFF_ignored");
    dwell(4'b0111, 7'b1111001, 1'b1, "f2_d3");
    chk(K_RDY, 7'd1, "commitABCD_ready");
    dwell(4'b1110, 7'b0100001, 1'b1, "f3_d0");
    dwell(4'b1101, 7'b1000110, 1'b1, "f3_d1");
    dwell(4'b1011, 7'b0000011, 1'b1, "f3_d2");
    dwell(4'b0111, 7'b0001000, 1'b1, "f3_d3");
    // Load on the boundary cycle waits for the following frame
    value = 16'h5678;
    load = 1'b1;
    chk(K_RDY, 7'd0, "load5678_ack");
    dwell(4'b1110, 7'b0100001, 1'b1, "f4_d0");
    dwell(4'b1101, 7'b1000110, 1'b1, "f4_d1");
    dwell(4'b1011, 7'b0000011, 1'b1, "f4_d2");
    dwell(4'b0111, 7'b0001000, 1'b1, "f4_d3");
    chk(K_RDY, 7'd1, "commit5678_ready");
    dwell(4'b1110, 7'b0000000, 1'b1, "f5_d0");
    dwell(4'b1101, 7'b1111000, 1'b1, "f5_d1");
    dwell(4'b1011, 7'b0000010, 1'b1, "f5_d2");
    dwell(4'b0111, 7'b0010010, 1'b1, "f5_d3");
    // Leading-zero blanking, dp does not override it
    blank_lz = 1'b1;
    dp = 4'b1111;
    idle_load(16'h0040, "load0040_ack");
    dwell(4'b1110, 7'b1000000, 1'b0, "lz_d0");
    dwell(4'b1101, 7'b0011001, 1'b0, "lz_d1");
    dwell(4'b1011, OFF, 1'b1, "lz_d2");
    dwell(4'b0111, OFF, 1'b1, "lz_d3");
    dp = 4'b0000;
    idle_load(16'h0000, "load0000_ack");
    dwell(4'b1110, 7'b1000000, 1'b1, "lz0_d0");
    dwell(4'b1101, OFF, 1'b1, "lz0_d1");
    dwell(4'b1011, OFF, 1'b1, "lz0_d2");
    dwell(4'b0111, OFF, 1'b1, "lz0_d3");
    blank_lz = 1'b0;
    // Illegal anode patterns and sticky error
    an_n = 4'b1100;
    chk(K_SEG, OFF, "illegal_seg");
    chk(K_ERR, 7'd1, "illegal_err");
    tick();
    an_n = 4'b1111;
    chk(K_ERR, 7'd1, "err_sticky");
    chk(K_SEG, OFF, "none_seg");
    tick();
    an_n = 4'b1010;
    err_clr = 1'b1;
    chk(K_ERR, 7'd1, "err_set_wins");
    tick();
    an_n = 4'b1111;
    chk(K_ERR, 7'd0, "err_cleared");
    tick();
    err_clr = 1'b0;
    chk(K_ERR, 7'd0, "err_stays_clear");
    tick();
    // Blink with a 16-cycle period
    idle_load(16'h8888, "load8888_ack");
    dwell(4'b1110, 7'b0000000, 1'b1, "b_d0");
    dwell(4'b1101, 7'b0000000, 1'b1, "b_d1");
    dwell(4'b1011, 7'b0000000, 1'b1, "b_d2");
    dwell(4'b0111, 7'b0000000, 1'b1, "b_d3");
    blink_en = 1'b1;
    an_n = 4'b1110;
    for (int i = 0; i < 16 && bc != 4'd0; i++) tick();
    for (int i = 0; i < 16; i++) begin
      chk(K_SEG, i < 8 ? 7'b0000000 : OFF, i < 8 ? "blink_on" : "blink_off");
      tick();
    end
    blink_en = 1'b0;
    // Reset while an update is pending
    idle_load(16'h1357, "load1357_ack");
    an_n = 4'b1101;
    tick();
    tick();
    do_reset("rst_mid");
    an_n = 4'b1111;
    chk(K_RDY, 7'd1, "post_rst_ready");
    tick();
    dwell(4'b1110, 7'b1000000, 1'b1, "pr_d0");
    dwell(4'b1101, 7'b1000000, 1'b1, "pr_d1");
    dwell(4'b1011, 7'b1000000, 1'b1, "pr_d2");
    dwell(4'b0111, 7'b1000000, 1'b1, "pr_d3");
    chk(K_RDY, 7'd1, "post_rst_ready_end");
    tick();
    tick();
    @(negedge clk);
    #1;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d unchecked entries expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
